// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants for the 1x3 router ingress synchroniser
package router_pkg;
    localparam int NUM_PORTS = 3;
    localparam int ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;
    localparam int TIMEOUT_DEFAULT = 30;
endpackage

// File: rtl/router_sync_if.sv
// rtl/router_sync_if.sv - FSM/FIFO-facing signal bundle of router_sync
interface router_sync_if;
    import router_pkg::*;

    logic                  detect_add;
    logic [ADDR_W-1:0]     data_in;
    logic                  write_enb_reg;
    logic                  read_enb_0, read_enb_1, read_enb_2;
    logic                  empty_0, empty_1, empty_2;
    logic                  full_0, full_1, full_2;
    logic [NUM_PORTS-1:0]  write_enb;
    logic                  fifo_full;
    logic                  vld_out_0, vld_out_1, vld_out_2;
    logic                  soft_reset_0, soft_reset_1, soft_reset_2;

    modport master (
        output detect_add, data_in, write_enb_reg,
        output read_enb_0, read_enb_1, read_enb_2,
        output empty_0, empty_1, empty_2,
        output full_0, full_1, full_2,
        input  write_enb, fifo_full,
        input  vld_out_0, vld_out_1, vld_out_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2
    );

    modport slave (
        input  detect_add, data_in, write_enb_reg,
        input  read_enb_0, read_enb_1, read_enb_2,
        input  empty_0, empty_1, empty_2,
        input  full_0, full_1, full_2,
        output write_enb, fifo_full,
        output vld_out_0, vld_out_1, vld_out_2,
        output soft_reset_0, soft_reset_1, soft_reset_2
    );
endinterface

// File: rtl/router_sync_timer.sv
// rtl/router_sync_timer.sv - per-port stall counter issuing a one-cycle FIFO soft reset
module router_sync_timer #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_soft_reset;
    logic             w_stall;

    assign w_stall    = vld & ~rd;
    assign soft_reset = r_soft_reset;

    // Counter restarts on the pulse so a persisting stall re-arms a full window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
        end else if (!w_stall) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b1;
        end else begin
            r_cnt        <= r_cnt + CNT_W'(1);
            r_soft_reset <= 1'b0;
        end
    end
endmodule

// File: rtl/router_sync.sv
// rtl/router_sync.sv - router ingress synchroniser: address latch, write steering, FIFO timeouts
module router_sync
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 5
) (
    input  logic         clk,
    input  logic         rst,
    router_sync_if.slave bus
);
    logic [ADDR_W-1:0]    r_addr;
    logic [NUM_PORTS-1:0] w_write_enb;
    logic                 w_fifo_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_addr <= ADDR_INVALID;
        else if (bus.detect_add)
            r_addr <= bus.data_in;
    end

    // Steering uses the registered address, so a same-cycle capture affects only later writes.
    always_comb begin
        w_write_enb = '0;
        w_fifo_full = 1'b0;
        case (r_addr)
            2'd0: begin
                w_write_enb[0] = bus.write_enb_reg;
                w_fifo_full    = bus.full_0;
            end
            2'd1: begin
                w_write_enb[1] = bus.write_enb_reg;
                w_fifo_full    = bus.full_1;
            end
            2'd2: begin
                w_write_enb[2] = bus.write_enb_reg;
                w_fifo_full    = bus.full_2;
            end
            default: begin
                w_write_enb = '0;
                w_fifo_full = 1'b0;
            end
        endcase
    end

    assign bus.write_enb = w_write_enb;
    assign bus.fifo_full = w_fifo_full;
    assign bus.vld_out_0 = ~bus.empty_0;
    assign bus.vld_out_1 = ~bus.empty_1;
    assign bus.vld_out_2 = ~bus.empty_2;

    router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_0 (
        .clk(clk), .rst(rst), .vld(~bus.empty_0), .rd(bus.read_enb_0),
        .soft_reset(bus.soft_reset_0)
    );
    router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_1 (
        .clk(clk), .rst(rst), .vld(~bus.empty_1), .rd(bus.read_enb_1),
        .soft_reset(bus.soft_reset_1)
    );
    router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_2 (
        .clk(clk), .rst(rst), .vld(~bus.empty_2), .rd(bus.read_enb_2),
        .soft_reset(bus.soft_reset_2)
    );
endmodule
